// File: rtl/gt_tx_bringup_sequencer.sv
// ---------------------------------------------------------------------------
// gt_tx_bringup_sequencer
//
// Brings up the TX side of a transceiver wizard and supervises it. The
// sequence is: hold reset_all, wait for TX reset done, wait for TX
// buffer-bypass alignment, wait for a run of clean cycles, then report the
// link as up. Any timeout, bypass error or status drop triggers a retry.
// After MAX_RETRIES consecutive retries the block parks in FAIL until
// enable is dropped.
//
// Ports
//   clock                  in   free-running clock, rising edge
//   reset                  in   synchronous, active-high
//   enable                 in   request to bring up and hold the TX link
//   gt_reset_all           out  wizard reset_all (registered)
//   gt_reset_tx_done       in   wizard TX reset done (asynchronous)
//   gt_buffbypass_tx_done  in   TX buffer-bypass done (asynchronous)
//   gt_buffbypass_tx_error in   TX buffer-bypass error (asynchronous)
//   link_up                out  link stable and usable (registered)
//   link_fail              out  retries exhausted (registered)
//   retry_count[3:0]       out  retries consumed since IDLE or last UP
//   state[2:0]             out  current state encoding
// ---------------------------------------------------------------------------
module gt_tx_bringup_sequencer #(
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic       gt_reset_all,
  input  logic       gt_reset_tx_done,
  input  logic       gt_buffbypass_tx_done,
  input  logic       gt_buffbypass_tx_error,
  output logic       link_up,
  output logic       link_fail,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RESET    = 3'd1,
    ST_WAIT_TX  = 3'd2,
    ST_WAIT_BYP = 3'd3,
    ST_STABLE   = 3'd4,
    ST_UP       = 3'd5,
    ST_FAIL     = 3'd6
  } state_e;

  // The timer only has to reach the largest per-state limit before saturating.
  localparam int unsigned MAX_LIMIT_0 = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned MAX_LIMIT   = (MAX_LIMIT_0 > STABLE_CYCLES) ? MAX_LIMIT_0 : STABLE_CYCLES;
  localparam int unsigned TW          = $clog2(MAX_LIMIT + 1);

  // A state exits on the cycle whose timer value is limit-1, so it lasts
  // exactly 'limit' cycles.
  localparam logic [TW-1:0] RST_LAST = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMR_MAX  = {TW{1'b1}};
  localparam logic [3:0]    RETRY_LIM = 4'(MAX_RETRIES);

  logic [1:0]    tx_done_sync_q;
  logic [1:0]    byp_done_sync_q;
  logic [1:0]    byp_err_sync_q;
  logic          tx_done_s;
  logic          byp_done_s;
  logic          byp_err_s;
  logic          link_bad_s;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    retry_q, retry_d;
  logic          retry_req_s;
  logic          gt_reset_all_q;
  logic          link_up_q;
  logic          link_fail_q;

  // Two-flop synchronizers for the asynchronous wizard status inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_done_sync_q  <= 2'b00;
      byp_done_sync_q <= 2'b00;
      byp_err_sync_q  <= 2'b00;
    end else begin
      tx_done_sync_q  <= {tx_done_sync_q[0],  gt_reset_tx_done};
      byp_done_sync_q <= {byp_done_sync_q[0], gt_buffbypass_tx_done};
      byp_err_sync_q  <= {byp_err_sync_q[0],  gt_buffbypass_tx_error};
    end
  end

  assign tx_done_s  = tx_done_sync_q[1];
  assign byp_done_s = byp_done_sync_q[1];
  assign byp_err_s  = byp_err_sync_q[1];

  // Condition that invalidates a STABLE/UP link.
  assign link_bad_s = ~tx_done_s | ~byp_done_s | byp_err_s;

  // Next-state, retry counter and timer computation.
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    retry_req_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        retry_d = 4'd0;
        if (enable) begin
          state_d = ST_RESET;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESET: begin
        if (timer_q >= RST_LAST) begin
          state_d = ST_WAIT_TX;
        end else begin
          state_d = ST_RESET;
        end
      end
      ST_WAIT_TX: begin
        if (tx_done_s) begin
          state_d = ST_WAIT_BYP;
        end else if (timer_q >= TO_LAST) begin
          retry_req_s = 1'b1;
        end else begin
          state_d = ST_WAIT_TX;
        end
      end
      ST_WAIT_BYP: begin
        // Error wins over done when both are seen in the same cycle.
        if (byp_err_s) begin
          retry_req_s = 1'b1;
        end else if (byp_done_s) begin
          state_d = ST_STABLE;
        end else if (timer_q >= TO_LAST) begin
          retry_req_s = 1'b1;
        end else begin
          state_d = ST_WAIT_BYP;
        end
      end
      ST_STABLE: begin
        if (link_bad_s) begin
          retry_req_s = 1'b1;
        end else if (timer_q >= STB_LAST) begin
          state_d = ST_UP;
          retry_d = 4'd0;
        end else begin
          state_d = ST_STABLE;
        end
      end
      ST_UP: begin
        if (link_bad_s) begin
          retry_req_s = 1'b1;
        end else begin
          state_d = ST_UP;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_IDLE;
        retry_d = 4'd0;
      end
    endcase

    if (retry_req_s) begin
      if (retry_q == RETRY_LIM) begin
        state_d = ST_FAIL;
      end else begin
        state_d = ST_RESET;
        retry_d = retry_q + 4'd1;
      end
    end else begin
      retry_d = retry_d;
    end

    // Dropping enable overrides everything and clears the retry history
    // on the way into IDLE.
    if (!enable) begin
      state_d = ST_IDLE;
      retry_d = 4'd0;
    end else begin
      state_d = state_d;
    end

    if (state_d != state_q) begin
      timer_d = '0;
    end else if (timer_q == TMR_MAX) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // State, timer, retry counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      retry_q        <= 4'd0;
      gt_reset_all_q <= 1'b1;
      link_up_q      <= 1'b0;
      link_fail_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      retry_q        <= retry_d;
      gt_reset_all_q <= (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAIL);
      link_up_q      <= (state_d == ST_UP);
      link_fail_q    <= (state_d == ST_FAIL);
    end
  end

  assign gt_reset_all = gt_reset_all_q;
  assign link_up      = link_up_q;
  assign link_fail    = link_fail_q;
  assign retry_count  = retry_q;
  assign state        = state_q;

endmodule
